// File: rtl/types.sv
// Shared LSU types: data word, memory op encoding {store, unsigned, size} and FSM states.
package lsu_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [3:0] {
    LB  = 4'b0000,
    LH  = 4'b0001,
    LW  = 4'b0010,
    LBU = 4'b0100,
    LHU = 4'b0101,
    SB  = 4'b1000,
    SH  = 4'b1001,
    SW  = 4'b1010
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Any encoding outside the defined set behaves as a plain word load.
  function automatic lsu_op_t op_norm(input lsu_op_t op);
    case (op)
      LB, LH, LW, LBU, LHU, SB, SH, SW: return op;
      default:                          return LW;
    endcase
  endfunction

  function automatic logic misaligned(input lsu_op_t op, input logic [1:0] addr_lo);
    case (op[1:0])
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store strobes and replicated write data, load byte/halfword extraction and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  addr_lo,
  input  word_t       wdata,
  input  word_t       rdata,
  output logic [3:0]  wstrb,
  output word_t       wdata_lane,
  output word_t       rdata_ext
);

  word_t shifted;

  always_comb begin
    wstrb      = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = '0;
    shifted    = rdata >> {addr_lo, 3'b000};
    case (op[1:0])
      SZ_B: begin
        wstrb      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = op[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = op[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
    endcase
    if (!op[3]) wstrb = 4'b0000;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, IDLE -> BUS -> RESP, misaligned accesses optionally trapped.
module lsu
  import lsu_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  lsu_op_t     req_op,
  input  word_t       req_addr,
  input  word_t       req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output word_t       mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output word_t       mem_wdata,
  input  word_t       mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output word_t       rsp_data,
  output logic        rsp_err,
  output lsu_state_t  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the offering side holds its payload until the transfer.

  lsu_state_t state, state_next;
  logic       alive;
  lsu_op_t    op_q;
  word_t      addr_q, wdata_q, rsp_data_q;
  logic       rsp_err_q;
  lsu_op_t    op_in;
  logic       mis_in;
  logic       accept;
  logic [3:0] strb;
  word_t      lane_data, ext_data;

  assign op_in  = op_norm(req_op);
  assign mis_in = ALIGN_CHECK && misaligned(op_in, req_addr[1:0]);
  assign accept = (state == IDLE) && alive && req_valid;

  lsu_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .wstrb      (strb),
    .wdata_lane (lane_data),
    .rdata_ext  (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = alive;
        if (alive && req_valid) state_next = mis_in ? RESP : BUS;
      end
      BUS: begin
        mem_valid = 1'b1;
        if (mem_ready) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // alive keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive      <= 1'b0;
      op_q       <= LW;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        op_q       <= op_in;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rsp_err_q  <= mis_in;
        rsp_data_q <= '0;
      end else if (state == BUS && mem_ready) begin
        rsp_data_q <= op_q[3] ? '0 : ext_data;
      end
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_we    = mem_valid & op_q[3];
  assign mem_wstrb = mem_valid ? strb : 4'b0000;
  assign mem_wdata = lane_data;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: reset, loads, stores, misalignment, stalls and mid-transaction reset.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  lsu_op_t     req_op;
  word_t       req_addr;
  word_t       req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  word_t       mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  word_t       mem_wdata;
  word_t       mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  word_t       rsp_data;
  logic        rsp_err;
  lsu_state_t  fsm_state;

  int checks = 0;
  int errors = 0;

  lsu #(.ALIGN_CHECK(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request, let the bus complete at once, report what was seen.
  // lat counts cycles from the accept cycle through the first response cycle; 0 means timeout.
  task automatic run_txn(input lsu_op_t op, input word_t addr, input word_t wd, input word_t rd,
                         output word_t data, output logic err, output int lat,
                         output logic saw_mem, output word_t m_addr, output logic [3:0] m_strb,
                         output word_t m_wdata, output logic m_we);
    saw_mem = 1'b0;
    m_addr  = '0;
    m_strb  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    mem_ready = 1'b1;
    mem_rdata = rd;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 2;
    while (!rsp_valid && lat < 20) begin
      if (mem_valid && !saw_mem) begin
        saw_mem = 1'b1;
        m_addr  = mem_addr;
        m_strb  = mem_wstrb;
        m_wdata = mem_wdata;
        m_we    = mem_we;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = 0;
    data = rsp_data;
    err  = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_valid, rsp_valid, rsp_err, mem_we, req_ready} !== 5'b0 || rsp_data !== 32'h0 ||
        mem_wstrb !== 4'h0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: mv=%b rv=%b re=%b we=%b rr=%b rd=%h strb=%h st=%0d, required all zero, IDLE",
               mem_valid, rsp_valid, rsp_err, mem_we, req_ready, rsp_data, mem_wstrb, fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b required 0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %b required 1", req_ready);
    end
  endtask

  task automatic test_lw();
    word_t d, ma, mw; logic e, sm, we; int lat; logic [3:0] st;
    run_txn(LW, 32'h100, 32'h0, 32'hDEADBEEF, d, e, lat, sm, ma, st, mw, we);
    checks++;
    if (d !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL lw_data: got %h err %b required deadbeef err 0", d, e);
    end
    checks++;
    if (lat !== 3 || sm !== 1'b1 || ma !== 32'h100 || we !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus: lat %0d mem %b addr %h we %b required lat 3 mem 1 addr 100 we 0", lat, sm, ma, we);
    end
  endtask

  task automatic test_loads();
    lsu_op_t ops[4]  = '{LB, LBU, LH, LHU};
    word_t   addrs[4] = '{32'h103, 32'h103, 32'h102, 32'h302};
    word_t   rds[4]   = '{32'h80123456, 32'h80123456, 32'h80010000, 32'hBEEF1234};
    word_t   exps[4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000BEEF};
    word_t d, ma, mw; logic e, sm, we; int lat; logic [3:0] st;
    for (int i = 0; i < 4; i++) begin
      run_txn(ops[i], addrs[i], 32'h0, rds[i], d, e, lat, sm, ma, st, mw, we);
      checks++;
      if (d !== exps[i] || e !== 1'b0 || ma !== {addrs[i][31:2], 2'b00}) begin
        errors++;
        $display("FAIL load_%0d: data %h err %b addr %h required %h err 0 addr %h",
                 i, d, e, ma, exps[i], {addrs[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_stores();
    lsu_op_t    ops[3]   = '{SH, SB, SW};
    word_t      addrs[3] = '{32'h202, 32'h001, 32'h10C};
    word_t      wds[3]   = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
    word_t      eaddr[3] = '{32'h200, 32'h000, 32'h10C};
    logic [3:0] estrb[3] = '{4'b1100, 4'b0010, 4'b1111};
    word_t      ewd[3]   = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D};
    word_t d, ma, mw; logic e, sm, we; int lat; logic [3:0] st;
    for (int i = 0; i < 3; i++) begin
      run_txn(ops[i], addrs[i], wds[i], 32'hFFFFFFFF, d, e, lat, sm, ma, st, mw, we);
      checks++;
      if (ma !== eaddr[i] || st !== estrb[i] || mw !== ewd[i] || we !== 1'b1) begin
        errors++;
        $display("FAIL store_bus_%0d: addr %h strb %b wdata %h we %b required %h %b %h 1",
                 i, ma, st, mw, we, eaddr[i], estrb[i], ewd[i]);
      end
      checks++;
      if (d !== 32'h0 || e !== 1'b0 || lat !== 3) begin
        errors++;
        $display("FAIL store_rsp_%0d: data %h err %b lat %0d required 0 0 3", i, d, e, lat);
      end
    end
  endtask

  task automatic test_misaligned();
    lsu_op_t ops[2]   = '{LW, SH};
    word_t   addrs[2] = '{32'h101, 32'h203};
    word_t d, ma, mw; logic e, sm, we; int lat; logic [3:0] st;
    for (int i = 0; i < 2; i++) begin
      run_txn(ops[i], addrs[i], 32'h55, 32'h12345678, d, e, lat, sm, ma, st, mw, we);
      checks++;
      if (sm !== 1'b0 || e !== 1'b1 || lat !== 2 || d !== 32'h0) begin
        errors++;
        $display("FAIL misaligned_%0d: mem %b err %b lat %0d data %h required mem 0 err 1 lat 2 data 0",
                 i, sm, e, lat, d);
      end
    end
  endtask

  task automatic test_unknown_op();
    word_t d, ma, mw; logic e, sm, we; int lat; logic [3:0] st;
    run_txn(lsu_op_t'(4'hF), 32'h40, 32'h99, 32'h11223344, d, e, lat, sm, ma, st, mw, we);
    checks++;
    if (d !== 32'h11223344 || we !== 1'b0 || st !== 4'h0 || e !== 1'b0 || ma !== 32'h40) begin
      errors++;
      $display("FAIL unknown_op: data %h we %b strb %b err %b addr %h required 11223344 0 0000 0 40",
               d, we, st, e, ma);
    end
  endtask

  task automatic test_stall();
    logic ok;
    @(negedge clk);
    req_valid = 1'b1; req_op = SW; req_addr = 32'h3FC; req_wdata = 32'h01020304;
    mem_ready = 1'b0; rsp_ready = 1'b0; mem_rdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_rdata = $urandom_range(0, 32'h7FFFFFFF);
      ok = mem_valid === 1'b1 && mem_addr === 32'h3FC && mem_wstrb === 4'hF &&
           mem_wdata === 32'h01020304 && mem_we === 1'b1 && req_ready === 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bus_stall_%0d: mv %b addr %h strb %b wd %h we %b rr %b required 1 3fc 1111 01020304 1 0",
                 i, mem_valid, mem_addr, mem_wstrb, mem_wdata, mem_we, req_ready);
      end
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ok = rsp_valid === 1'b1 && rsp_data === 32'h0 && rsp_err === 1'b0 &&
           req_ready === 1'b0 && mem_valid === 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rsp_stall_%0d: rv %b data %h err %b rr %b mv %b required 1 0 0 0 0",
                 i, rsp_valid, rsp_data, rsp_err, req_ready, mem_valid);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: rr %b rv %b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    word_t d, ma, mw; logic e, sm, we, seen_rsp; int lat; logic [3:0] st;
    @(negedge clk);
    req_valid = 1'b1; req_op = LW; req_addr = 32'h500; req_wdata = 32'h0;
    mem_ready = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_bus_entry: mv %b required 1", mem_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: mv %b rr %b rv %b we %b required 0 0 0 0",
               mem_valid, req_ready, rsp_valid, mem_we);
    end
    mem_ready = 1'b1;
    seen_rsp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
    checks++;
    if (seen_rsp !== 1'b0 || req_ready !== 1'b1 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset_recover: rsp_seen %b rr %b st %0d required 0 1 IDLE", seen_rsp, req_ready, fsm_state);
    end
    run_txn(LW, 32'h504, 32'h0, 32'h5A5A0001, d, e, lat, sm, ma, st, mw, we);
    checks++;
    if (d !== 32'h5A5A0001 || e !== 1'b0 || lat !== 3 || ma !== 32'h504) begin
      errors++;
      $display("FAIL post_reset_txn: data %h err %b lat %0d addr %h required 5a5a0001 0 3 504", d, e, lat, ma);
    end
  endtask

  initial begin
    req_valid = 1'b0;
    req_op    = LW;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_misaligned();
    test_unknown_op();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ALIGN_CHECK, default 1: 1 = flag misaligned accesses and suppress them; 0 = issue misaligned accesses with the address truncated to word.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  LSU accepts a request.
REQ-006 SHALL have port req_op  input  lsu_op_t  one of LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-007 SHALL have port req_addr  input  word_t  byte address, taken from the ALU ADD result.
REQ-008 SHALL have port req_wdata  input  word_t  store data, right-aligned.
REQ-009 SHALL have port mem_valid  output  1  bus request.
REQ-010 SHALL have port mem_ready  input  1  bus accepts and completes the request this cycle.
REQ-011 SHALL have port mem_addr  output  word_t  word-aligned address, bits [1:0] = 0.
REQ-012 SHALL have port mem_we  output  1  1 = store.
REQ-013 SHALL have port mem_wstrb  output  4  byte enables.
REQ-014 SHALL have port mem_wdata  output  word_t  store data, lane-shifted.
REQ-015 SHALL have port mem_rdata  input  word_t  load data, valid when mem_valid and mem_ready are both high.
REQ-016 SHALL have port rsp_valid  output  1  response present.
REQ-017 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-018 SHALL have port rsp_data  output  word_t  extended load data; 0 for stores.
REQ-019 SHALL have port rsp_err  output  1  misaligned access.

Function
REQ-020 SHALL implement FSM states IDLE, BUS, RESP.
REQ-021 In IDLE: req_ready = 1, and a handshake on req_valid registers op, addr and wdata, then moves to BUS, or to RESP with rsp_err = 1 if misaligned and ALIGN_CHECK = 1.
REQ-022 Misaligned is defined as: halfword with addr[0] = 1; word with addr[1:0] != 0.
REQ-023 In BUS: mem_valid = 1, and mem_addr, mem_we, mem_wstrb and mem_wdata SHALL be held stable until mem_ready.
REQ-024 In BUS, on mem_ready, the FSM SHALL capture the extended load data and move to RESP.
REQ-025 In RESP: rsp_valid = 1; on rsp_ready move to IDLE. A new request is not accepted in the same cycle.
REQ-026 Store strobes SHALL be: SB gives 4'b0001 << addr[1:0]; SH gives 4'b0011 << addr[1:0]; SW gives 4'b1111.
REQ-027 mem_wdata SHALL be the byte or halfword replicated across all lanes.
REQ-028 Load extraction SHALL take the byte or halfword at lane addr[1:0].
REQ-029 LB and LH SHALL sign-extend to 32 bits; LBU and LHU SHALL zero-extend.
REQ-030 Latency SHALL be: accept cycle -> BUS -> RESP. Minimum 3 cycles from request to response with mem_ready tied high.
REQ-031 A misaligned access SHALL reach RESP on the cycle after accept, with mem_valid never asserted.
REQ-032 req_ready SHALL be 0 outside IDLE; at most one transaction is outstanding.
REQ-033 rsp_data and rsp_err SHALL stay stable while rsp_valid = 1 and rsp_ready = 0.
REQ-034 An unknown lsu_op_t encoding SHALL be treated as LW.

Reset
REQ-035 While rst_n = 0, the FSM SHALL be in IDLE.
REQ-036 While rst_n = 0, outputs SHALL be: mem_valid = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, mem_wstrb = 0, mem_we = 0.
REQ-037 While rst_n = 0, req_ready SHALL be 0; it goes to 1 on the first edge after release.
REQ-038 Reset asserted mid-transaction SHALL abandon it without generating a response; the bus side must tolerate the dropped mem_valid.

Structure
REQ-039 lsu_op_t, and the word_t already in use, SHALL be defined in types.sv.
REQ-040 lsu_op_t SHALL be encoded as {store, unsigned, size[1:0]}.
REQ-041 One combinational sub-module, lsu_align, SHALL produce wstrb and wdata and extract/extend rdata from op and addr[1:0]; lsu instantiates it.

Verification
REQ-042 Test 1: LW at addr 0x100, mem_rdata 0xDEADBEEF, mem_ready high -> rsp_data 0xDEADBEEF, rsp_err 0, mem_addr 0x100, 3 cycles.
REQ-043 Test 2: LB at addr 0x103, mem_rdata 0x80xxxxxx -> rsp_data 0xFFFFFF80; LBU at the same addr -> rsp_data 0x00000080.
REQ-044 Test 3: SH at addr 0x202, wdata 0x1234ABCD -> mem_addr 0x200, mem_wstrb 4'b1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-045 Test 4: LW at addr 0x101 with ALIGN_CHECK = 1 -> mem_valid never asserted, rsp_err 1, rsp_valid on the cycle after accept.
REQ-046 Test 5: mem_ready held low 5 cycles, rsp_ready held low 3 cycles -> bus outputs and response stable throughout, req_ready 0 until the response is accepted.
REQ-047 Test 6: rst_n pulsed low during BUS -> mem_valid drops immediately, no rsp_valid, next request completes normally.
